task_dispatch_arbiter: RTL and testbench
========================================

TASK_DISPATCH_ARBITER -- requirements
Module: task_dispatch_arbiter

Interface
REQ-001 SHALL have parameter N_CORES, default 4, meaning the number of cores sharing one conflict-free task stream (2..16).
REQ-002 SHALL have parameter CORE_ID_W, default $clog2(N_CORES), meaning the width of core indices.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_valid  input  1  a conflict-free task is offered.
REQ-006 s_ready  output  1  the offered task is accepted this cycle.
REQ-007 s_rdata  input  task_t  the offered task.
REQ-008 s_cq_slot  input  cq_slice_slot_t  the CQ slot of the offered task.
REQ-009 s_thread  input  thread_id_t  the thread id assigned to the offered task.
REQ-010 unlock_valid  output  1  one-cycle pulse that releases a thread.
REQ-011 unlock_thread  output  thread_id_t  the thread being released.
REQ-012 core_req  input  N_CORES  per-core level request for work.
REQ-013 core_task_valid  output  N_CORES  per-core one-cycle task delivery pulse.
REQ-014 core_task  output  N_CORES x task_t  per-core registered task.
REQ-015 core_cq_slot  output  N_CORES x cq_slice_slot_t  per-core registered CQ slot.
REQ-016 core_done  input  N_CORES  per-core one-cycle finish pulse.
REQ-017 dispatch_en  input  1  when low, no new grants are made.
REQ-018 n_running  output  CORE_ID_W+1  count of cores in RUN or UNLOCK.
REQ-019 all_idle  output  1  every core is IDLE.
REQ-020 err_spurious_done  output  1  sticky flag: core_done arrived for a core not in RUN.

Function
REQ-021 Each core SHALL have an FSM with states IDLE, RUN and UNLOCK, plus a stored thread_id_t register.
REQ-022 Eligible cores SHALL be those with state==IDLE and core_req high; grant condition SHALL be s_valid & dispatch_en & (any eligible).
REQ-023 s_ready SHALL be combinational and equal to the grant condition; it SHALL NOT depend on s_ready itself.
REQ-024 The grantee SHALL be the first eligible core at or after the dispatch round-robin pointer, with wrap from N_CORES-1 to 0.
REQ-025 On a grant edge, the dispatch pointer SHALL become (grantee+1) mod N_CORES, the grantee SHALL move IDLE->RUN, and s_rdata, s_cq_slot and s_thread SHALL be captured into that core's registers.
REQ-026 core_task_valid[grantee] SHALL pulse high for exactly one cycle, in the cycle after the grant (latency 1); core_task and core_cq_slot SHALL hold their values until the next grant to that core.
REQ-027 At most one grant SHALL occur per cycle.
REQ-028 core_done[c] in RUN SHALL move core c RUN->UNLOCK.
REQ-029 core_done[c] in IDLE or UNLOCK SHALL be ignored for state purposes and SHALL set err_spurious_done, which holds until reset.
REQ-030 Among UNLOCK cores, one per cycle SHALL be selected round-robin from an independent unlock pointer.
REQ-031 On a selection edge: unlock_valid is registered high next cycle, unlock_thread is the selected core's stored thread, the core moves UNLOCK->IDLE, and the unlock pointer becomes (selected+1) mod N_CORES.
REQ-032 unlock_valid SHALL be low in any cycle following an edge with no UNLOCK cores.
REQ-033 A core returned to IDLE SHALL be grant-eligible in the cycle after its unlock edge, not earlier.
REQ-034 A grant and an unlock selection in the same cycle SHALL both take effect, on different cores.
REQ-035 core_done in the same cycle as that core's grant SHALL be treated as spurious: the core is still IDLE, so REQ-029 applies.
REQ-036 dispatch_en low SHALL block new grants only; RUN and UNLOCK progress SHALL be unaffected.
REQ-037 n_running SHALL equal the registered count of non-IDLE cores; all_idle SHALL be (n_running==0).

Reset
REQ-038 While rst is high, all of the following SHALL hold asynchronously: every core IDLE, both pointers 0, core_task_valid=0, unlock_valid=0, unlock_thread=0, core_task=0, core_cq_slot=0, err_spurious_done=0, n_running=0, all_idle=1.
REQ-039 Reset mid-operation SHALL discard in-flight tasks without generating an unlock; thread recovery SHALL be the job of the serializer's own reset.
REQ-040 s_ready SHALL be 0 while rst is high.

Verification
REQ-041 Single grant: core_req=4'b0100, s_valid=1, s_thread=5 -> s_ready=1 that cycle; core_task_valid=4'b0100 next cycle; pointer=3; n_running=1.
REQ-042 Round-robin fairness: core_req=4'b1111 held and s_valid held -> grants go to cores 0,1,2,3 on consecutive cycles, then s_ready=0; all_idle=0.
REQ-043 Simultaneous finishes: cores 0 and 2 RUN with threads 7 and 3, core_done=4'b0101 -> unlock_thread 7 and then 3 on two consecutive cycles, each with unlock_valid=1; both cores IDLE afterwards.
REQ-044 Grant and unlock in the same cycle: core 1 in UNLOCK, core 0 requesting, s_valid=1 -> both occur; core 1 is not regranted until the following cycle.
REQ-045 Spurious done and dispatch_en: core_done[3] while core 3 IDLE -> err_spurious_done=1 and stays 1; dispatch_en=0 with s_valid=1 and requests present -> s_ready=0, while a RUN core's done still unlocks.
REQ-046 Asynchronous reset: assert rst mid-cycle with 2 cores RUN -> outputs reach reset values immediately; no unlock_valid pulse; all_idle=1.

Source files
------------

// File: rtl/task_dispatch_arbiter.sv
// -----------------------------------------------------------------------------
// task_dispatch_arbiter
//
// Hands a stream of conflict-free tasks to N_CORES worker cores and hands each
// finished task's thread id back to the serializer.
//
// Each core runs a small IDLE -> RUN -> UNLOCK -> IDLE cycle:
//   * IDLE   : the core may be granted the offered task when it requests work.
//   * RUN    : the core is executing; core_done moves it to UNLOCK.
//   * UNLOCK : the core waits its turn to release its thread id.
//
// Grants and unlock selections each use their own round-robin pointer. At
// most one of each happens per cycle, and both may happen in the same cycle
// because they always involve cores in different states.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   s_valid / s_ready               task offer / combinational accept
//   s_rdata, s_cq_slot, s_thread    offered task, its CQ slot, its thread id
//   unlock_valid, unlock_thread     registered one-cycle thread release
//   core_req                        per-core level request for work
//   core_task_valid                 per-core one-cycle delivery pulse
//   core_task, core_cq_slot         per-core registered task / CQ slot (flat)
//   core_done                       per-core one-cycle finish pulse
//   dispatch_en                     when low, no new grants are made
//   n_running, all_idle             registered occupancy status
//   err_spurious_done               sticky: core_done seen outside RUN
// -----------------------------------------------------------------------------
module task_dispatch_arbiter #(
    parameter int N_CORES   = 4,
    parameter int CORE_ID_W = $clog2(N_CORES),
    parameter int TASK_W    = 16,
    parameter int CQ_SLOT_W = 6,
    parameter int THREAD_W  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [TASK_W-1:0]              s_rdata,
    input  logic [CQ_SLOT_W-1:0]           s_cq_slot,
    input  logic [THREAD_W-1:0]            s_thread,
    output logic                           unlock_valid,
    output logic [THREAD_W-1:0]            unlock_thread,
    input  logic [N_CORES-1:0]             core_req,
    output logic [N_CORES-1:0]             core_task_valid,
    output logic [N_CORES*TASK_W-1:0]      core_task,
    output logic [N_CORES*CQ_SLOT_W-1:0]   core_cq_slot,
    input  logic [N_CORES-1:0]             core_done,
    input  logic                           dispatch_en,
    output logic [CORE_ID_W:0]             n_running,
    output logic                           all_idle,
    output logic                           err_spurious_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UNLOCK = 2'd2
    } core_state_e;

    core_state_e              state_q  [N_CORES];
    core_state_e              state_d  [N_CORES];
    logic [THREAD_W-1:0]      thread_q [N_CORES];
    logic [THREAD_W-1:0]      thread_d [N_CORES];
    logic [TASK_W-1:0]        task_q   [N_CORES];
    logic [TASK_W-1:0]        task_d   [N_CORES];
    logic [CQ_SLOT_W-1:0]     slot_q   [N_CORES];
    logic [CQ_SLOT_W-1:0]     slot_d   [N_CORES];

    logic [CORE_ID_W-1:0]     ptr_q, ptr_d;
    logic [CORE_ID_W-1:0]     uptr_q, uptr_d;
    logic [N_CORES-1:0]       ctv_q, ctv_d;
    logic                     uv_q, uv_d;
    logic [THREAD_W-1:0]      ut_q, ut_d;
    logic                     err_q, err_d;
    logic [CORE_ID_W:0]       nrun_q, nrun_d;
    logic                     all_idle_q, all_idle_d;

    logic [N_CORES-1:0]       eligible;
    logic [N_CORES-1:0]       run_mask;
    logic                     grant_s;
    logic                     grant_hit;
    int                       grant_idx;
    logic                     unl_hit;
    int                       unl_idx;

    // Per-core eligibility and RUN mask derived from the current states.
    always_comb begin
        eligible = '0;
        run_mask = '0;
        for (int c = 0; c < N_CORES; c++) begin
            eligible[c] = (state_q[c] == ST_IDLE) & core_req[c];
            run_mask[c] = (state_q[c] == ST_RUN);
        end
    end

    // Round-robin search for the grantee (first eligible at/after ptr_q).
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = 0;
        for (int i = 0; i < N_CORES; i++) begin
            if (!grant_hit && eligible[(int'(ptr_q) + i) % N_CORES]) begin
                grant_hit = 1'b1;
                grant_idx = (int'(ptr_q) + i) % N_CORES;
            end else begin
                grant_hit = grant_hit;
            end
        end
    end

    // Round-robin search for the core to unlock (first UNLOCK at/after uptr_q).
    always_comb begin
        unl_hit = 1'b0;
        unl_idx = 0;
        for (int i = 0; i < N_CORES; i++) begin
            if (!unl_hit && (state_q[(int'(uptr_q) + i) % N_CORES] == ST_UNLOCK)) begin
                unl_hit = 1'b1;
                unl_idx = (int'(uptr_q) + i) % N_CORES;
            end else begin
                unl_hit = unl_hit;
            end
        end
    end

    // Accept is purely a function of inputs and current state; forced low in reset.
    always_comb begin
        grant_s = s_valid & dispatch_en & grant_hit;
        s_ready = grant_s & ~rst;
    end

    // Next-state computation for every register in the block.
    always_comb begin
        ptr_d  = ptr_q;
        uptr_d = uptr_q;
        ctv_d  = '0;
        uv_d   = 1'b0;
        ut_d   = ut_q;
        // A done for a core outside RUN (including one being granted this
        // very cycle, which is still IDLE) is flagged and otherwise ignored.
        err_d  = err_q | (|(core_done & ~run_mask));
        nrun_d = '0;
        for (int c = 0; c < N_CORES; c++) begin
            state_d[c]  = state_q[c];
            thread_d[c] = thread_q[c];
            task_d[c]   = task_q[c];
            slot_d[c]   = slot_q[c];
            case (state_q[c])
                ST_IDLE: begin
                    if (grant_s && (grant_idx == c)) begin
                        state_d[c]  = ST_RUN;
                        thread_d[c] = s_thread;
                        task_d[c]   = s_rdata;
                        slot_d[c]   = s_cq_slot;
                        ctv_d[c]    = 1'b1;
                    end else begin
                        state_d[c] = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (core_done[c]) begin
                        state_d[c] = ST_UNLOCK;
                    end else begin
                        state_d[c] = ST_RUN;
                    end
                end
                ST_UNLOCK: begin
                    if (unl_hit && (unl_idx == c)) begin
                        state_d[c] = ST_IDLE;
                        uv_d       = 1'b1;
                        ut_d       = thread_q[c];
                    end else begin
                        state_d[c] = ST_UNLOCK;
                    end
                end
                default: begin
                    state_d[c] = ST_IDLE;
                end
            endcase
            if (state_d[c] != ST_IDLE) begin
                nrun_d = nrun_d + (CORE_ID_W+1)'(1'b1);
            end else begin
                nrun_d = nrun_d;
            end
        end
        if (grant_s) begin
            ptr_d = CORE_ID_W'((grant_idx + 1) % N_CORES);
        end else begin
            ptr_d = ptr_q;
        end
        if (unl_hit) begin
            uptr_d = CORE_ID_W'((unl_idx + 1) % N_CORES);
        end else begin
            uptr_d = uptr_q;
        end
        all_idle_d = (nrun_d == '0);
    end

    // State and output registers; reset discards in-flight work with no unlock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CORES; c++) begin
                state_q[c]  <= ST_IDLE;
                thread_q[c] <= '0;
                task_q[c]   <= '0;
                slot_q[c]   <= '0;
            end
            ptr_q      <= '0;
            uptr_q     <= '0;
            ctv_q      <= '0;
            uv_q       <= 1'b0;
            ut_q       <= '0;
            err_q      <= 1'b0;
            nrun_q     <= '0;
            all_idle_q <= 1'b1;
        end else begin
            for (int c = 0; c < N_CORES; c++) begin
                state_q[c]  <= state_d[c];
                thread_q[c] <= thread_d[c];
                task_q[c]   <= task_d[c];
                slot_q[c]   <= slot_d[c];
            end
            ptr_q      <= ptr_d;
            uptr_q     <= uptr_d;
            ctv_q      <= ctv_d;
            uv_q       <= uv_d;
            ut_q       <= ut_d;
            err_q      <= err_d;
            nrun_q     <= nrun_d;
            all_idle_q <= all_idle_d;
        end
    end

    // Flatten per-core registers onto the output buses.
    for (genvar g = 0; g < N_CORES; g++) begin : g_flat
        assign core_task[g*TASK_W +: TASK_W]          = task_q[g];
        assign core_cq_slot[g*CQ_SLOT_W +: CQ_SLOT_W] = slot_q[g];
    end

    assign core_task_valid   = ctv_q;
    assign unlock_valid      = uv_q;
    assign unlock_thread     = ut_q;
    assign err_spurious_done = err_q;
    assign n_running         = nrun_q;
    assign all_idle          = all_idle_q;

endmodule

// File: tb/tb_task_dispatch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_task_dispatch_arbiter
//
// Drives directed scenarios and randomized traffic into task_dispatch_arbiter
// and compares every observable output against a per-core reference model
// (state per core as an integer: 0 idle, 1 running, 2 waiting to unlock).
// -----------------------------------------------------------------------------
module tb_task_dispatch_arbiter;

    localparam int N  = 4;
    localparam int TW = 16;
    localparam int SW = 6;
    localparam int HW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [TW-1:0]   s_rdata;
    logic [SW-1:0]   s_cq_slot;
    logic [HW-1:0]   s_thread;
    logic            unlock_valid;
    logic [HW-1:0]   unlock_thread;
    logic [N-1:0]    core_req;
    logic [N-1:0]    core_task_valid;
    logic [N*TW-1:0] core_task;
    logic [N*SW-1:0] core_cq_slot;
    logic [N-1:0]    core_done;
    logic            dispatch_en;
    logic [2:0]      n_running;
    logic            all_idle;
    logic            err_spurious_done;

    task_dispatch_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_rdata           (s_rdata),
        .s_cq_slot         (s_cq_slot),
        .s_thread          (s_thread),
        .unlock_valid      (unlock_valid),
        .unlock_thread     (unlock_thread),
        .core_req          (core_req),
        .core_task_valid   (core_task_valid),
        .core_task         (core_task),
        .core_cq_slot      (core_cq_slot),
        .core_done         (core_done),
        .dispatch_en       (dispatch_en),
        .n_running         (n_running),
        .all_idle          (all_idle),
        .err_spurious_done (err_spurious_done)
    );

    always #5 clk = ~clk;

    int err_cnt   = 0;
    int check_cnt = 0;

    // Reference model
    int          m_st   [N];
    int          m_thr  [N];
    int          m_task [N];
    int          m_slot [N];
    int          m_ptr, m_uptr;
    logic [N-1:0] m_ctv;
    logic        m_uv;
    int          m_ut;
    logic        m_err;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_st[c] = 0; m_thr[c] = 0; m_task[c] = 0; m_slot[c] = 0;
        end
        m_ptr = 0; m_uptr = 0; m_ctv = '0; m_uv = 1'b0; m_ut = 0; m_err = 1'b0;
    endtask

    task automatic check_outputs();
        logic [N*TW-1:0] exp_task;
        logic [N*SW-1:0] exp_slot;
        int busy;
        busy = 0;
        for (int c = 0; c < N; c++) begin
            exp_task[c*TW +: TW] = TW'(m_task[c]);
            exp_slot[c*SW +: SW] = SW'(m_slot[c]);
            if (m_st[c] != 0) busy++;
        end
        check_eq("core_task_valid", 64'(core_task_valid), 64'(m_ctv));
        check_eq("unlock_valid", 64'(unlock_valid), 64'(m_uv));
        if (m_uv) check_eq("unlock_thread", 64'(unlock_thread), 64'(m_ut));
        check_eq("core_task", 64'(core_task), 64'(exp_task));
        check_eq("core_cq_slot", 64'(core_cq_slot), 64'(exp_slot));
        check_eq("n_running", 64'(n_running), 64'(busy));
        check_eq("all_idle", 64'(all_idle), 64'(busy == 0));
        check_eq("err_spurious_done", 64'(err_spurious_done), 64'(m_err));
    endtask

    // One clock cycle: drive inputs, check accept, advance model, check outputs.
    task automatic step(input logic v, input logic en, input logic [N-1:0] req,
                        input logic [N-1:0] dn, input logic [TW-1:0] d,
                        input logic [SW-1:0] sl, input logic [HW-1:0] th);
        int g, u, c;
        @(negedge clk);
        s_valid = v; dispatch_en = en; core_req = req; core_done = dn;
        s_rdata = d; s_cq_slot = sl; s_thread = th;
        #1;
        g = -1;
        u = -1;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (g < 0 && m_st[c] == 0 && req[c]) g = c;
        end
        if (!(v && en)) g = -1;
        for (int k = 0; k < N; k++) begin
            c = (m_uptr + k) % N;
            if (u < 0 && m_st[c] == 2) u = c;
        end
        check_eq("s_ready", 64'(s_ready), 64'(g >= 0));
        m_ctv = '0;
        m_uv  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (dn[k]) begin
                if (m_st[k] == 1) m_st[k] = 2;
                else m_err = 1'b1;
            end
        end
        if (g >= 0) begin
            m_st[g] = 1; m_thr[g] = th; m_task[g] = d; m_slot[g] = sl;
            m_ctv[g] = 1'b1;
            m_ptr = (g + 1) % N;
        end
        if (u >= 0) begin
            m_st[u] = 0; m_uv = 1'b1; m_ut = m_thr[u];
            m_uptr = (u + 1) % N;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b1, '0, '0, '0, '0, '0);
    endtask

    // Asserts reset away from any clock edge and checks it acts at once.
    task automatic async_reset();
        @(posedge clk);
        #3;
        s_valid = 1'b1; dispatch_en = 1'b1; core_req = '1; core_done = '0;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_s_ready", 64'(s_ready), 64'd0);
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_unlock_valid", 64'(unlock_valid), 64'd0);
        check_eq("rst_hold_s_ready", 64'(s_ready), 64'd0);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0; core_req = '0;
    endtask

    task automatic random_phase(input int cycles);
        logic [N-1:0] req, dn;
        for (int t = 0; t < cycles; t++) begin
            for (int c = 0; c < N; c++) begin
                req[c] = ($urandom_range(0, 3) != 0);
                if (m_st[c] == 1) dn[c] = ($urandom_range(0, 2) == 0);
                else dn[c] = ($urandom_range(0, 39) == 0);
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, req, dn,
                 TW'($urandom), SW'($urandom), HW'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b1; dispatch_en = 1'b1; core_req = '1; core_done = '0;
        s_rdata = '0; s_cq_slot = '0; s_thread = '0;
        model_reset();
        #2;
        check_eq("init_s_ready", 64'(s_ready), 64'd0);
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0; core_req = '0;

        // Single grant to core 2 with thread 5, then a second request from
        // core 1 must lose to core 3 (pointer now 3).
        step(1'b1, 1'b1, 4'b0100, '0, 16'h1234, 6'd9, 4'd5);
        step(1'b1, 1'b1, 4'b1010, '0, 16'h00aa, 6'd1, 4'd6);
        async_reset();

        // Round-robin fairness with all cores requesting.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 4'b1111, '0, TW'(16'h100 + i), SW'(i), HW'(i));
        async_reset();

        // Two simultaneous finishes unlock in pointer order on consecutive cycles.
        step(1'b1, 1'b1, 4'b0001, '0, 16'h0a0a, 6'd2, 4'd7);
        step(1'b1, 1'b1, 4'b0100, '0, 16'h0b0b, 6'd3, 4'd3);
        step(1'b0, 1'b1, '0, 4'b0101, '0, '0, '0);
        idle_step();
        idle_step();

        // Core 1 unlocks while core 0 is granted; core 1 requests immediately.
        step(1'b1, 1'b1, 4'b0010, '0, 16'h0c0c, 6'd4, 4'd1);
        step(1'b0, 1'b1, '0, 4'b0010, '0, '0, '0);
        step(1'b1, 1'b1, 4'b0011, '0, 16'h0d0d, 6'd5, 4'd2);
        step(1'b1, 1'b1, 4'b0010, '0, 16'h0e0e, 6'd6, 4'd8);

        // Spurious done on an idle core, then dispatch disabled while a running
        // core still finishes and unlocks. Same-cycle grant+done is spurious too.
        step(1'b0, 1'b1, '0, 4'b1000, '0, '0, '0);
        step(1'b1, 1'b0, 4'b1100, 4'b0010, 16'h0f0f, 6'd7, 4'd9);
        step(1'b1, 1'b0, 4'b1100, '0, 16'h0f0f, 6'd7, 4'd9);
        step(1'b1, 1'b1, 4'b0100, 4'b0100, 16'h1111, 6'd8, 4'd10);

        random_phase(400);
        async_reset();
        random_phase(300);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
